requantizer: RTL and testbench
==============================

REQUANTIZER -- requirements
Module: requantizer

Interface
REQ-001 SHALL have parameter DATA_W, default 32: signed input sample width.
REQ-002 SHALL have parameter GAIN_W, default 16: signed gain width.
REQ-003 SHALL have parameter OUT_W, default 8: signed output width, 2..DATA_W.
REQ-004 SHALL have parameter NCH, default 4: number of per-channel parameter slots, at least 2; CW = clog2(NCH).
REQ-005 SHALL have ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- cfg_we  in  1  parameter-slot write strobe.
- cfg_addr  in  CW  slot index.
- cfg_gain  in  GAIN_W  signed gain.
- cfg_bias  in  DATA_W  signed bias.
- cfg_shift  in  5  right-shift amount.
- cfg_round  in  1  1 = round half up, 0 = truncate.
- s_valid  in  1  input sample valid.
- s_ready  out  1  input accepted when s_valid && s_ready.
- s_data  in  DATA_W  signed sample.
- s_ch  in  CW  parameter slot for the sample.
- m_valid  out  1  output valid.
- m_ready  in  1  downstream ready.
- m_data  out  OUT_W  signed result.
- m_sat  out  1  result was clipped.
- sat_clr  in  1  synchronous clear of sat_count.
- sat_count  out  16  saturation event counter.

Function
REQ-006 SHALL hold NCH slots, each {gain, bias, shift, round}; a write with cfg_we=1 updates slot cfg_addr at the clock edge; writes with cfg_addr >= NCH SHALL be ignored.
REQ-007 SHALL use a two-stage pipeline: stage 1 captures product = s_data*gain (DATA_W+GAIN_W bits, signed) plus the slot's bias, shift and round; stage 2 drives m_data and m_sat.
REQ-008 SHALL advance both stages when adv = !m_valid || m_ready; s_ready SHALL equal adv combinationally.
REQ-009 SHALL use the slot value read in the acceptance cycle; a same-cycle write to that slot SHALL NOT affect the accepted sample.
REQ-010 SHALL use slot 0 when s_ch >= NCH.
REQ-011 SHALL have a latency of 2 cycles from acceptance to m_valid=1 when m_ready is held high, with one sample per cycle throughput.
REQ-012 SHALL compute, in full product width:
- r = (product + (round && shift>0 ? 1<<(shift-1) : 0)) >>> shift, arithmetic shift.
- v = r + sign-extended bias.
REQ-013 SHALL saturate v to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; m_sat=1 exactly when clipping occurred.
REQ-014 SHALL keep m_data and m_sat stable while m_valid && !m_ready.
REQ-015 SHALL NOT drop, duplicate or reorder samples under any m_ready pattern.
REQ-016 SHALL increment sat_count on each transfer (m_valid && m_ready && m_sat); sat_count SHALL stick at 16'hFFFF.
REQ-017 SHALL give sat_clr priority over a same-cycle increment; sat_count SHALL be 0 the next cycle.

Reset
REQ-018 SHALL, on reset assertion, immediately clear m_valid, m_data, m_sat, sat_count and both stage valid bits, discarding in-flight samples.
REQ-019 SHALL reset every slot to gain=1, bias=0, shift=0, round=0, giving identity with saturation.
REQ-020 SHALL drive s_ready=1 while reset is deasserted and the pipeline is empty.

Verification
REQ-021 Identity: after reset, m_ready=1, s_data=100, s_ch=0 -> m_data=100, m_sat=0 exactly 2 cycles later.
REQ-022 Saturation: s_data=1000, then -1000 -> m_data=127 with m_sat=1, then -128 with m_sat=1; sat_count=2; pulse sat_clr -> sat_count=0.
REQ-023 Rounding: slot 1 = {gain=3, shift=1, bias=0}, with round=1 and round=0:
- s_data=5 -> 8 (round=1), 7 (round=0).
- s_data=-5 -> -7 (round=1), -8 (round=0).
- bias=10, round=0, s_data=5 -> 17.
REQ-024 Backpressure: m_ready=0 for 4 cycles while offering 1,2,3 on ch0 -> s_ready drops once both stages are full; on m_ready=1 the outputs are 1,2,3 in order with no loss.
REQ-025 Config race: write slot 0 gain=2 in the same cycle that s_data=7 is accepted on ch0 -> output 7; the next sample 7 -> output 14.
REQ-026 Reset mid-flight: assert reset with 2 samples in flight -> m_valid=0 at once, no stale output after release, and slot 0 gain is back to 1.

Source files
------------

// File: rtl/requantizer.sv
`default_nettype none
// ============================================================================
//  Module  : requantizer
//  Brief   : Per-channel gain/shift/bias requantizer with saturation,
//            two-stage valid/ready pipeline and saturation event counter.
//  Rev     : 1.0  initial release
// ============================================================================
module requantizer #(
    parameter int DATA_W = 32,
    parameter int GAIN_W = 16,
    parameter int OUT_W  = 8,
    parameter int NCH    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cfg_we,
    input  logic [$clog2(NCH)-1:0]     cfg_addr,
    input  logic signed [GAIN_W-1:0]   cfg_gain,
    input  logic signed [DATA_W-1:0]   cfg_bias,
    input  logic [4:0]                 cfg_shift,
    input  logic                       cfg_round,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic signed [DATA_W-1:0]   s_data,
    input  logic [$clog2(NCH)-1:0]     s_ch,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic signed [OUT_W-1:0]    m_data,
    output logic                       m_sat,
    input  logic                       sat_clr,
    output logic [15:0]                sat_count
);

    localparam int c_cw = $clog2(NCH);
    localparam int c_pw = DATA_W + GAIN_W;

    logic signed [GAIN_W-1:0] r_gain  [NCH];
    logic signed [DATA_W-1:0] r_bias  [NCH];
    logic [4:0]               r_shift [NCH];
    logic                     r_round [NCH];

    // Addresses at or beyond NCH match no slot and are therefore dropped.
    for (genvar g = 0; g < NCH; g++) begin : g_slot
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_gain[g]  <= GAIN_W'(1);
                r_bias[g]  <= '0;
                r_shift[g] <= '0;
                r_round[g] <= 1'b0;
            end else if (cfg_we && (cfg_addr == c_cw'(g))) begin
                r_gain[g]  <= cfg_gain;
                r_bias[g]  <= cfg_bias;
                r_shift[g] <= cfg_shift;
                r_round[g] <= cfg_round;
            end
        end
    end

    logic                     w_adv;
    logic [c_cw-1:0]          w_sel;
    logic signed [GAIN_W-1:0] w_gain_sel;
    logic signed [c_pw-1:0]   w_prod;

    logic                     r_s1_valid;
    logic signed [c_pw-1:0]   r_s1_prod;
    logic signed [DATA_W-1:0] r_s1_bias;
    logic [4:0]               r_s1_shift;
    logic                     r_s1_round;

    logic                     r_m_valid;
    logic signed [OUT_W-1:0]  r_m_data;
    logic                     r_m_sat;
    logic [15:0]              r_sat_count;

    assign w_adv      = !r_m_valid || m_ready;
    assign s_ready    = w_adv;
    assign w_sel      = (32'(s_ch) < 32'(NCH)) ? s_ch : '0;
    assign w_gain_sel = r_gain[w_sel];
    assign w_prod     = s_data * w_gain_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_prod  <= '0;
            r_s1_bias  <= '0;
            r_s1_shift <= '0;
            r_s1_round <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= s_valid;
            if (s_valid) begin
                r_s1_prod  <= w_prod;
                r_s1_bias  <= r_bias[w_sel];
                r_s1_shift <= r_shift[w_sel];
                r_s1_round <= r_round[w_sel];
            end
        end
    end

    logic signed [c_pw-1:0]  w_rnd;
    logic signed [c_pw-1:0]  w_sum;
    logic signed [c_pw-1:0]  w_r;
    logic signed [c_pw-1:0]  w_v;
    logic                    w_fits;
    logic signed [OUT_W-1:0] w_out;

    assign w_rnd  = (r_s1_round && (r_s1_shift != 5'd0))
                  ? ({{(c_pw-1){1'b0}}, 1'b1} << (r_s1_shift - 5'd1)) : '0;
    assign w_sum  = r_s1_prod + w_rnd;
    assign w_r    = w_sum >>> r_s1_shift;
    assign w_v    = w_r + {{(c_pw-DATA_W){r_s1_bias[DATA_W-1]}}, r_s1_bias};
    // In range exactly when every bit above the output sign bit copies it.
    assign w_fits = (w_v[c_pw-1:OUT_W-1] == {(c_pw-OUT_W+1){w_v[c_pw-1]}});
    assign w_out  = w_fits ? w_v[OUT_W-1:0]
                  : (w_v[c_pw-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_sat   <= 1'b0;
        end else if (w_adv) begin
            r_m_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_m_data <= w_out;
                r_m_sat  <= !w_fits;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sat_count <= '0;
        end else if (sat_clr) begin
            r_sat_count <= '0;
        end else if (r_m_valid && m_ready && r_m_sat && (r_sat_count != 16'hFFFF)) begin
            r_sat_count <= r_sat_count + 16'd1;
        end
    end

    assign m_valid   = r_m_valid;
    assign m_data    = r_m_data;
    assign m_sat     = r_m_sat;
    assign sat_count = r_sat_count;

endmodule
`default_nettype wire

// File: tb/tb_requantizer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_requantizer
//  Brief   : Self-checking bench for requantizer: vector table, directed
//            sequences and randomized traffic against an arithmetic model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_requantizer;

    localparam int DATA_W = 32;
    localparam int GAIN_W = 16;
    localparam int OUT_W  = 8;
    localparam int NCH    = 4;
    localparam int c_cw   = $clog2(NCH);
    localparam longint c_omax = (longint'(1) <<< (OUT_W-1)) - 1;
    localparam longint c_omin = -(longint'(1) <<< (OUT_W-1));

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     cfg_we = 1'b0;
    logic [c_cw-1:0]          cfg_addr = '0;
    logic signed [GAIN_W-1:0] cfg_gain = '0;
    logic signed [DATA_W-1:0] cfg_bias = '0;
    logic [4:0]               cfg_shift = '0;
    logic                     cfg_round = 1'b0;
    logic                     s_valid = 1'b0;
    logic                     s_ready;
    logic signed [DATA_W-1:0] s_data = '0;
    logic [c_cw-1:0]          s_ch = '0;
    logic                     m_valid;
    logic                     m_ready = 1'b0;
    logic signed [OUT_W-1:0]  m_data;
    logic                     m_sat;
    logic                     sat_clr = 1'b0;
    logic [15:0]              sat_count;

    requantizer #(.DATA_W(DATA_W), .GAIN_W(GAIN_W), .OUT_W(OUT_W), .NCH(NCH)) dut (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_gain(cfg_gain), .cfg_bias(cfg_bias),
        .cfg_shift(cfg_shift), .cfg_round(cfg_round),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_ch(s_ch),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sat(m_sat),
        .sat_clr(sat_clr), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int errors = 0;

    typedef struct { longint data; bit sat; } exp_t;
    typedef struct { longint gain; longint bias; int shift; bit rnd; } slot_t;
    typedef struct {
        longint gain; longint bias; int shift; bit rnd;
        longint din; longint exp_data; bit exp_sat;
    } vec_t;

    exp_t        q[$];
    slot_t       slots[NCH];
    logic [15:0] mdl_cnt = '0;

    function automatic exp_t model(longint d, slot_t s);
        exp_t   e;
        longint v;
        v = d * s.gain;
        if (s.rnd && s.shift > 0) v = v + (longint'(1) <<< (s.shift - 1));
        v = (v >>> s.shift) + s.bias;
        e.sat  = (v > c_omax) || (v < c_omin);
        e.data = (v > c_omax) ? c_omax : ((v < c_omin) ? c_omin : v);
        return e;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: looks at what the coming rising edge will do.
    always @(negedge clk) begin
        exp_t e;
        bit   xfer;
        bit   esat;
        if (reset) begin
            q.delete();
            mdl_cnt = '0;
            for (int i = 0; i < NCH; i++) slots[i] = '{1, 0, 0, 1'b0};
        end else begin
            check("sat_count", longint'(sat_count), longint'(mdl_cnt));
            xfer = m_valid && m_ready;
            esat = 1'b0;
            if (xfer) begin
                if (q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = q.pop_front();
                    esat = e.sat;
                    check("sb_data", longint'(m_data), e.data);
                    check("sb_sat", longint'(m_sat), longint'(e.sat));
                end
            end
            if (sat_clr) mdl_cnt = '0;
            else if (xfer && esat && mdl_cnt != 16'hFFFF) mdl_cnt = mdl_cnt + 16'd1;
            if (s_valid && s_ready)
                q.push_back(model(longint'(s_data), slots[(int'(s_ch) < NCH) ? int'(s_ch) : 0]));
            if (cfg_we && int'(cfg_addr) < NCH)
                slots[cfg_addr] = '{longint'(cfg_gain), longint'(cfg_bias), int'(cfg_shift), cfg_round};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int addr, input longint g, input longint b, input int sh, input bit rnd);
        cfg_we = 1'b1; cfg_addr = c_cw'(addr); cfg_gain = GAIN_W'(g);
        cfg_bias = DATA_W'(b); cfg_shift = 5'(sh); cfg_round = rnd;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic send(input longint d, input int ch);
        int n = 0;
        s_valid = 1'b1; s_data = DATA_W'(d); s_ch = c_cw'(ch);
        while (!s_ready && n < 20) begin tick(); n++; end
        if (!s_ready) check("send_timeout", 0, 1);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic wait_out(output longint d, output longint s);
        int n = 0;
        while (!m_valid && n < 20) begin tick(); n++; end
        if (!m_valid) check("out_timeout", 0, 1);
        d = longint'(m_data);
        s = longint'(m_sat);
    endtask

    vec_t vecs[14];

    initial begin
        longint d, s;
        vecs[0]  = '{3,   0, 1, 1,     5,    8, 0};
        vecs[1]  = '{3,   0, 1, 0,     5,    7, 0};
        vecs[2]  = '{3,   0, 1, 1,    -5,   -7, 0};
        vecs[3]  = '{3,   0, 1, 0,    -5,   -8, 0};
        vecs[4]  = '{3,  10, 1, 0,     5,   17, 0};
        vecs[5]  = '{1,   0, 0, 0,  1000,  127, 1};
        vecs[6]  = '{1,   0, 0, 0, -1000, -128, 1};
        vecs[7]  = '{1,   0, 0, 0,   127,  127, 0};
        vecs[8]  = '{1,   0, 0, 0,  -128, -128, 0};
        vecs[9]  = '{1,   0, 0, 0,   128,  127, 1};
        vecs[10] = '{1, -10, 0, 0,  -118, -128, 0};
        vecs[11] = '{1, -10, 0, 0,  -119, -128, 1};
        vecs[12] = '{1,   0, 2, 1,    -6,   -1, 0};
        vecs[13] = '{1,   0, 2, 1,     6,    2, 0};

        repeat (3) tick();
        check("reset_m_valid", longint'(m_valid), 0);
        check("reset_sat_count", longint'(sat_count), 0);
        reset = 1'b0;
        m_ready = 1'b1;
        #1;
        check("idle_s_ready", longint'(s_ready), 1);

        // Identity with exact two-cycle latency.
        s_valid = 1'b1; s_data = 100; s_ch = 0;
        tick();
        s_valid = 1'b0;
        check("id_not_yet", longint'(m_valid), 0);
        tick();
        check("id_valid", longint'(m_valid), 1);
        check("id_data", longint'(m_data), 100);
        check("id_sat", longint'(m_sat), 0);
        tick();

        // Saturation and counter clear.
        send(1000, 0);
        wait_out(d, s); check("sat_hi_data", d, 127); check("sat_hi_flag", s, 1);
        tick();
        send(-1000, 0);
        wait_out(d, s); check("sat_lo_data", d, -128); check("sat_lo_flag", s, 1);
        tick();
        check("sat_count_2", longint'(sat_count), 2);
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        check("sat_count_clr", longint'(sat_count), 0);

        foreach (vecs[i]) begin
            cfg_write(1, vecs[i].gain, vecs[i].bias, vecs[i].shift, vecs[i].rnd);
            send(vecs[i].din, 1);
            wait_out(d, s);
            check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
            check($sformatf("vec%0d_sat", i), s, longint'(vecs[i].exp_sat));
            tick();
        end

        // Backpressure: both stages fill, then drain in order.
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = 1; s_ch = 0;
        check("bp_rdy0", longint'(s_ready), 1);
        tick(); s_data = 2;
        check("bp_rdy1", longint'(s_ready), 1);
        tick(); s_data = 3;
        check("bp_rdy2", longint'(s_ready), 0);
        tick();
        check("bp_rdy3", longint'(s_ready), 0);
        check("bp_hold", longint'(m_data), 1);
        tick();
        m_ready = 1'b1;
        #1;
        check("bp_out1", longint'(m_data), 1);
        tick(); s_valid = 1'b0;
        check("bp_out2", longint'(m_data), 2);
        tick();
        check("bp_out3", longint'(m_data), 3);
        tick();
        check("bp_empty", longint'(m_valid), 0);

        // Config write in the acceptance cycle must not affect that sample.
        s_valid = 1'b1; s_data = 7; s_ch = 0;
        cfg_we = 1'b1; cfg_addr = 0; cfg_gain = 2; cfg_bias = 0; cfg_shift = 0; cfg_round = 0;
        tick();
        cfg_we = 1'b0;
        tick();
        s_valid = 1'b0;
        check("race_old", longint'(m_data), 7);
        tick();
        check("race_new", longint'(m_data), 14);
        tick();

        // Reset with two samples in flight.
        s_valid = 1'b1; s_data = 9; s_ch = 0;
        tick(); s_data = 10;
        tick(); s_valid = 1'b0;
        check("mid_valid_before", longint'(m_valid), 1);
        reset = 1'b1;
        #1;
        check("mid_valid_async", longint'(m_valid), 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("mid_no_stale", longint'(m_valid), 0);
            tick();
        end
        send(5, 0);
        wait_out(d, s);
        check("mid_gain_reset", d, 5);
        tick();

        // Randomized traffic against the scoreboard.
        for (int i = 0; i < 3000; i++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            sat_clr = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 15) == 0) begin
                cfg_we = 1'b1; cfg_addr = c_cw'($urandom);
                cfg_gain = GAIN_W'($urandom); cfg_bias = DATA_W'($urandom_range(0, 400)) - 200;
                cfg_shift = 5'($urandom); cfg_round = 1'($urandom);
            end else begin
                cfg_we = 1'b0;
            end
            s_valid = ($urandom_range(0, 2) != 0);
            s_data  = ($urandom_range(0, 1) != 0) ? DATA_W'($urandom)
                                                 : DATA_W'($urandom_range(0, 400)) - 200;
            s_ch    = c_cw'($urandom);
            tick();
        end
        cfg_we = 1'b0; s_valid = 1'b0; sat_clr = 1'b0; m_ready = 1'b1;
        repeat (6) tick();
        check("drain_queue_empty", longint'(q.size()), 0);
        check("drain_m_valid", longint'(m_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
`default_nettype wire
